// File: rtl/regfile_writeback_pkg.sv
// Shared types and sizing for the register-file writeback initiator.
`timescale 1ns/1ps
package regfile_wb_pkg;

  localparam int data_width   = 32;
  localparam int select_width = 5;
  localparam int fifo_depth   = 4;
  localparam int num_regs     = 2 ** select_width;
  localparam int ptr_w        = $clog2(fifo_depth);
  localparam int cnt_w        = ptr_w + 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [select_width-1:0] addr;
    logic [data_width-1:0]   data;
  } wb_entry_t;

  function automatic logic [num_regs-1:0] reg_onehot(input logic [select_width-1:0] a);
    return num_regs'(1) << a;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes plus register-file write port of the writeback block.
`timescale 1ns/1ps
interface regfile_writeback_if;
  import regfile_wb_pkg::*;

  logic                    alu_valid;
  logic                    alu_ready;
  logic [select_width-1:0] alu_addr;
  logic [data_width-1:0]   alu_data;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [select_width-1:0] mem_addr;
  logic [data_width-1:0]   mem_data;
  logic [data_width-1:0]   write_data;
  logic [select_width-1:0] write_address;
  logic                    RegWrite;
  logic [num_regs-1:0]     busy_mask;
  logic                    init_done;

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, write_data, write_address, RegWrite, busy_mask, init_done
  );

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, write_data, write_address, RegWrite, busy_mask, init_done
  );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// Result buffer: up to two pushes and one pop per cycle, with per-entry
// address visibility so the top can build the pending-write bitmap.
`timescale 1ns/1ps
module wb_fifo
  import regfile_wb_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [1:0]                                 push_cnt_i,
  input  wb_entry_t                                  push0_i,
  input  wb_entry_t                                  push1_i,
  input  logic                                       pop_i,
  output wb_entry_t                                  head_o,
  output logic [cnt_w-1:0]                           count_o,
  output logic [fifo_depth-1:0][select_width-1:0]    ent_addr_o,
  output logic [fifo_depth-1:0]                      ent_vld_o
);

  wb_entry_t          mem_q [fifo_depth];
  logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + ptr_w'(push_cnt_i);
    rd_ptr_d = rd_ptr_q + ptr_w'(pop_i);
    count_d  = count_q + cnt_w'(push_cnt_i) - cnt_w'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count/pointers only.
  always_ff @(posedge clk) begin
    if (push_cnt_i != 2'd0) mem_q[wr_ptr_q] <= push0_i;
    if (push_cnt_i == 2'd2) mem_q[wr_ptr_q + ptr_w'(1)] <= push1_i;
  end

  always_comb begin
    logic [ptr_w-1:0] off;
    off       = '0;
    ent_vld_o = '0;
    for (int i = 0; i < fifo_depth; i++) begin
      off           = ptr_w'(i) - rd_ptr_q;
      ent_vld_o[i]  = cnt_w'(off) < count_q;
      ent_addr_o[i] = mem_q[i].addr;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback initiator: zero-fills the file after reset, then
// drains buffered ALU/load results one write per cycle.
`timescale 1ns/1ps
module regfile_writeback
  import regfile_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  regfile_writeback_if.slave bus
);

  wb_state_e                   state_q;
  logic [select_width-1:0]     init_cnt_q;
  logic                        regwrite_q;
  logic [select_width-1:0]     waddr_q;
  logic [data_width-1:0]       wdata_q;

  logic [cnt_w-1:0]                        count, free;
  logic                                    mem_rdy, alu_rdy;
  logic                                    mem_push, alu_push;
  logic [1:0]                              push_cnt;
  wb_entry_t                               push0, push1, head;
  logic                                    pop;
  logic [fifo_depth-1:0][select_width-1:0] ent_addr;
  logic [fifo_depth-1:0]                   ent_vld;
  logic [num_regs-1:0]                     busy;

  // Readies use the registered free count; a same-cycle pop is not credited.
  always_comb begin
    free     = cnt_w'(fifo_depth) - count;
    mem_rdy  = (state_q == RUN) && (free >= cnt_w'(1));
    alu_rdy  = (state_q == RUN) &&
               ((free >= cnt_w'(2)) || ((free >= cnt_w'(1)) && !bus.mem_valid));
    mem_push = bus.mem_valid && mem_rdy && (bus.mem_addr != '0);
    alu_push = bus.alu_valid && alu_rdy && (bus.alu_addr != '0);
    push1    = '{addr: bus.alu_addr, data: bus.alu_data};
    push0    = mem_push ? '{addr: bus.mem_addr, data: bus.mem_data} : push1;
    push_cnt = {1'b0, mem_push} + {1'b0, alu_push};
    pop      = (state_q == RUN) && (count != '0);
  end

  wb_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_cnt_i (push_cnt),
    .push0_i    (push0),
    .push1_i    (push1),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .ent_addr_o (ent_addr),
    .ent_vld_o  (ent_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        INIT: begin
          regwrite_q <= 1'b1;
          waddr_q    <= init_cnt_q;
          wdata_q    <= '0;
          init_cnt_q <= init_cnt_q + select_width'(1);
          if (init_cnt_q == select_width'(num_regs - 1)) state_q <= RUN;
        end
        RUN: begin
          if (pop) begin
            regwrite_q <= 1'b1;
            waddr_q    <= head.addr;
            wdata_q    <= head.data;
          end else begin
            regwrite_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    busy = '0;
    if (state_q == INIT) begin
      busy = '1;
    end else begin
      for (int i = 0; i < fifo_depth; i++) begin
        if (ent_vld[i]) busy = busy | reg_onehot(ent_addr[i]);
      end
      if (regwrite_q) busy = busy | reg_onehot(waddr_q);
      busy[0] = 1'b0;
    end
  end

  assign bus.mem_ready     = mem_rdy;
  assign bus.alu_ready     = alu_rdy;
  assign bus.write_data    = wdata_q;
  assign bus.write_address = waddr_q;
  assign bus.RegWrite      = regwrite_q;
  assign bus.busy_mask     = busy;
  assign bus.init_done     = (state_q == RUN);

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed plus randomized bench for regfile_writeback against a queue model.
`timescale 1ns/1ps
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst;
  regfile_writeback_if bus ();

  regfile_writeback dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          writes_seen;
  int          accepted_nz;
  int          dut_stalls;
  ent_t        q[$];
  logic        out_v;
  logic [4:0]  out_a;
  logic [31:0] out_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) m[q[i].a] = 1'b1;
    if (out_v) m[out_a] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic step(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad);
    int   free;
    logic emr, ear;
    ent_t e;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    #1;
    free = DEPTH - q.size();
    emr  = (free >= 1);
    ear  = (free >= 2) || ((free >= 1) && !mv);
    chk("mem_ready", bus.mem_ready, emr);
    chk("alu_ready", bus.alu_ready, ear);
    if (!bus.alu_ready || !bus.mem_ready) dut_stalls++;
    @(posedge clk); #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      out_v = 1'b1; out_a = e.a; out_d = e.d;
    end else begin
      out_v = 1'b0;
    end
    if (mv && emr && ma != 5'd0) begin
      e.a = ma; e.d = md; q.push_back(e); accepted_nz++;
    end
    if (av && ear && aa != 5'd0) begin
      e.a = aa; e.d = ad; q.push_back(e); accepted_nz++;
    end
    chk("RegWrite", bus.RegWrite, out_v);
    chk("write_address", bus.write_address, out_a);
    chk("write_data", bus.write_data, out_d);
    chk("busy_mask", bus.busy_mask, model_busy());
    chk("init_done", bus.init_done, 1'b1);
    if (bus.RegWrite) writes_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd7; bus.mem_data = 32'h77;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 32'h99;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_RegWrite", bus.RegWrite, 1'b0);
    chk("rst_address", bus.write_address, 5'd0);
    chk("rst_data", bus.write_data, 32'd0);
    chk("rst_init_done", bus.init_done, 1'b0);
    chk("rst_busy", bus.busy_mask, 32'hFFFF_FFFF);
    chk("rst_mem_ready", bus.mem_ready, 1'b0);
    chk("rst_alu_ready", bus.alu_ready, 1'b0);
    rst = 1'b0;
    q.delete();
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      chk("init_RegWrite", bus.RegWrite, 1'b1);
      chk("init_address", bus.write_address, k);
      chk("init_data", bus.write_data, 32'd0);
      chk("init_done_edge", bus.init_done, (k == 31));
      chk("init_busy", bus.busy_mask, (k == 31) ? 32'h8000_0000 : 32'hFFFF_FFFF);
      chk("init_mem_ready", bus.mem_ready, (k == 31));
      chk("init_alu_ready", bus.alu_ready, (k == 31));
    end
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    out_v = 1'b1; out_a = 5'd31; out_d = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; writes_seen = 0; accepted_nz = 0; dut_stalls = 0;
    out_v = 1'b0; out_a = '0; out_d = '0;
    rst = 1'b1;

    do_reset();
    idle(2);

    // single ALU write
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    idle(3);

    // both producers on an empty buffer
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    idle(3);

    // address-0 result is handshaken but dropped
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    chk("addr0_busy", bus.busy_mask, 32'd0);
    chk("addr0_no_write", bus.RegWrite, 1'b0);
    idle(2);

    // sustained backpressure
    dut_stalls = 0;
    for (int i = 0; i < 20; i++)
      step(1'b1, 5'(1 + (i % 15)), 32'h1000 + i, 1'b1, 5'(16 + (i % 15)), 32'h2000 + i);
    chk("bp_stall_seen", (dut_stalls > 0), 1'b1);
    idle(6);

    // random traffic, including address 0 and duplicate destinations
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    idle(8);
    chk("write_count", writes_seen, accepted_nz);
    chk("drained_busy", bus.busy_mask, 32'd0);

    // reset with entries in flight
    step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0);
    do_reset();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
